data_path: RTL and testbench
============================

# data_path

Single-bus 32-bit CPU datapath: register file, bus multiplexer, ALU and the special registers (PC, IR, MDR, Y, Z, HI, LO, RA, PORT). Every transfer is bus-based. One enabled source drives the shared bus, and any enabled destination captures it on the rising clock edge. The block sits under the control unit, which sequences the `*out`/`*in` strobes and `ops` each step. It is also driven directly by testbenches.

## Interface
Parameters: none.

Ports, in the following positional order:
- `clock`  in  1  system clock; all registers update on the rising edge.
- `clear`  in  1  reset, asynchronous, active-low.
- `Mdatain`  in  32  memory read data, captured into MDR.
- `ops`  in  5  ALU operation select.
- `RAout, R0out…R15out, RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout, MDRout, PORTout`  in  1 each  bus source enables.
- `RAin, R0in…R15in, RYin, RZin, PCin, IRin, HIin, LOin, MDRin, PORTin`  in  1 each  register load enables.
- `Read`  in  1  MDR input select: 1 selects `Mdatain`, 0 selects the bus.
- `BusMuxOut`  out  32  current bus value, for observation. It is the last port.

## Operation
- Registers:
  - R0–R15, RA, PC, IR, HI, LO, MDR, Y and PORT are 32 bits each.
  - Z is 64 bits: ZHI = Z[63:32], ZLO = Z[31:0].
- Bus source priority, highest first: R0…R15, RA, PC, IR, HI, LO, ZHI, ZLO, MDR, PORT, Y.
  - With several `*out` strobes asserted, the highest-priority source wins.
  - With no `*out` asserted, the bus is 0.
- Load rules:
  - Each `Xin` loads register X from the bus.
  - MDR loads `Read ? Mdatain : bus`.
  - `RZin` loads the 64-bit ALU result into Z.
- ALU operands and result:
  - The ALU is combinational. A = Y register (always; `RYout` is not needed for this). B = bus.
  - The result is 64 bits. Single-word ops put their result in [31:0] and 0 in [63:32].
- `ops` encoding:
  - 00000 ADD: A+B
  - 00001 SUB: A−B
  - 00010 AND
  - 00011 OR
  - 00100 NOT: ~B
  - 00101 MUL: signed A×B, full 64 bits
  - 00110 DIV: signed; quotient in [31:0], remainder in [63:32]; truncates toward zero
  - 00111 SHR: logical, A >> B[4:0]
  - 01000 SHRA: arithmetic
  - 01001 SHL
  - 01010 ROR, by B[4:0]
  - 01011 ROL
  - 01100 NEG: 0−B
  - any other code: result 0
- Arithmetic wraps modulo 2^32. No flags.
- DIV by zero: quotient 0xFFFFFFFF, remainder = A.

## Timing
- Bus, ALU and `BusMuxOut` are combinational. A register strobed in cycle n holds the new value after rising edge n.
- Typical sequencing:
  - `RZin` in the same cycle as the B-source strobe.
  - `RZLOout`/`RZHIout` in a later cycle.
  - Minimum latency: operand to Z takes 1 edge; Z to destination takes 1 more edge.
- Simultaneous `Xout` and `Xin` on the same register: X reloads its own value.
- `clear`=0 asynchronously zeroes every register, including Z (64 bits) and PORT. The zeroing happens immediately, even mid-sequence, and the bus reads 0 while no strobe is asserted.
- After `clear` deasserts, the first rising edge loads normally.
- Strobes are sampled only at the rising edge. Their levels between edges are don't-care for register state.

## Configuration
- `DATAPATH_DIV_EN` defined: the DIV op (00110) is implemented as specified.
- `DATAPATH_DIV_EN` undefined: no divider hardware is built, and 00110 yields Z = 0.
- All other ops are unaffected either way.

## Test plan
- MUL:
  - Steps: reset; `Read`=1, `Mdatain`=0xFFFFFFFD, MDRin; MDRout+RYin; `Mdatain`=4, MDRin; MDRout+R2in; `ops`=00101, R2out+RYout+RZin; RZLOout+R1in; RZHIout+HIin.
  - Required: R1=0xFFFFFFF4, HI=0xFFFFFFFF. R2out wins the bus over RYout.
- ADD/SUB:
  - Y=7, R3=5. ADD → ZLO=12, ZHI=0. SUB → ZLO=2.
  - Y=0, B=1, SUB → ZLO=0xFFFFFFFF.
- Shifts and rotates:
  - Y=0x80000001, B=1: SHR → 0x40000000; SHRA → 0xC0000000; ROL → 0x00000003; ROR → 0xC0000000.
  - B=33 behaves as a shift of 1.
- DIV (with `DATAPATH_DIV_EN`):
  - Y=−7, B=2 → ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFF.
  - B=0 → ZLO=0xFFFFFFFF, ZHI=0xFFFFFFF9.
  - Without the macro → Z=0.
- MDR select:
  - `Read`=0 with R5=0x1234 and R5out → MDR=0x1234.
  - `Read`=1 → MDR=`Mdatain`.
  - No `*out` asserted → `BusMuxOut`=0.
- Reset mid-sequence:
  - Load R1=0xAA and Z=nonzero, then pulse `clear` low between edges.
  - R1, Z and HI read 0 at once.
  - The next strobed load succeeds.

Source files
------------

// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register file, priority bus mux, 64-bit ALU and special registers.
// Define DATAPATH_DIV_EN to build the signed divider; otherwise op 00110 yields Z = 0.
module data_path (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] Mdatain,
   input  logic [4:0]  ops,
   input  logic        RAout,
   input  logic        R0out,
   input  logic        R1out,
   input  logic        R2out,
   input  logic        R3out,
   input  logic        R4out,
   input  logic        R5out,
   input  logic        R6out,
   input  logic        R7out,
   input  logic        R8out,
   input  logic        R9out,
   input  logic        R10out,
   input  logic        R11out,
   input  logic        R12out,
   input  logic        R13out,
   input  logic        R14out,
   input  logic        R15out,
   input  logic        RYout,
   input  logic        RZHIout,
   input  logic        RZLOout,
   input  logic        PCout,
   input  logic        IRout,
   input  logic        HIout,
   input  logic        LOout,
   input  logic        MDRout,
   input  logic        PORTout,
   input  logic        RAin,
   input  logic        R0in,
   input  logic        R1in,
   input  logic        R2in,
   input  logic        R3in,
   input  logic        R4in,
   input  logic        R5in,
   input  logic        R6in,
   input  logic        R7in,
   input  logic        R8in,
   input  logic        R9in,
   input  logic        R10in,
   input  logic        R11in,
   input  logic        R12in,
   input  logic        R13in,
   input  logic        R14in,
   input  logic        R15in,
   input  logic        RYin,
   input  logic        RZin,
   input  logic        PCin,
   input  logic        IRin,
   input  logic        HIin,
   input  logic        LOin,
   input  logic        MDRin,
   input  logic        PORTin,
   input  logic        Read,
   output logic [31:0] BusMuxOut
);

   typedef enum logic [4:0] {
      ALU_ADD  = 5'b00000,
      ALU_SUB  = 5'b00001,
      ALU_AND  = 5'b00010,
      ALU_OR   = 5'b00011,
      ALU_NOT  = 5'b00100,
      ALU_MUL  = 5'b00101,
      ALU_DIV  = 5'b00110,
      ALU_SHR  = 5'b00111,
      ALU_SHRA = 5'b01000,
      ALU_SHL  = 5'b01001,
      ALU_ROR  = 5'b01010,
      ALU_ROL  = 5'b01011,
      ALU_NEG  = 5'b01100
   } alu_op_e;

   logic [31:0] r_q [16];
   logic [31:0] ra_q, pc_q, ir_q, hi_q, lo_q, mdr_q, y_q, port_q;
   logic [63:0] z_q;

   logic [31:0] mdr_d;
   logic [63:0] z_d;
   logic [31:0] bus;
   logic [15:0] r_out, r_in;

   assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
   assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

   // NOTE: combinational blocks use blocking '=' with a default first, so no latch is
   // inferred; here the sources are listed lowest priority first and the last hit wins.
   always_comb begin
      bus = '0;
      if (RYout)   bus = y_q;
      if (PORTout) bus = port_q;
      if (MDRout)  bus = mdr_q;
      if (RZLOout) bus = z_q[31:0];
      if (RZHIout) bus = z_q[63:32];
      if (LOout)   bus = lo_q;
      if (HIout)   bus = hi_q;
      if (IRout)   bus = ir_q;
      if (PCout)   bus = pc_q;
      if (RAout)   bus = ra_q;
      for (int i = 15; i >= 0; i--) begin
         if (r_out[i]) bus = r_q[i];
      end
   end

   assign BusMuxOut = bus;
   assign mdr_d     = Read ? Mdatain : bus;

   // Operand A is always Y; operand B is whatever is on the bus this cycle.
   logic [31:0]        alu_a, alu_b;
   logic [4:0]         sh;
   logic signed [63:0] a_sx, b_sx;

   assign alu_a = y_q;
   assign alu_b = bus;
   assign sh    = alu_b[4:0];
   assign a_sx  = {{32{alu_a[31]}}, alu_a};
   assign b_sx  = {{32{alu_b[31]}}, alu_b};

`ifdef DATAPATH_DIV_EN
   // Dividing at 64 bits keeps -2^31 / -1 well defined; it wraps to 0x80000000.
   logic [31:0] div_quo, div_rem;

   always_comb begin
      div_quo = 32'hFFFF_FFFF;
      div_rem = alu_a;
      if (alu_b != 32'h0) begin
         div_quo = 32'(a_sx / b_sx);
         div_rem = 32'(a_sx % b_sx);
      end
   end
`endif

   always_comb begin
      z_d = '0;
      case (alu_op_e'(ops))
         ALU_ADD:  z_d = {32'h0, alu_a + alu_b};
         ALU_SUB:  z_d = {32'h0, alu_a - alu_b};
         ALU_AND:  z_d = {32'h0, alu_a & alu_b};
         ALU_OR:   z_d = {32'h0, alu_a | alu_b};
         ALU_NOT:  z_d = {32'h0, ~alu_b};
         ALU_MUL:  z_d = a_sx * b_sx;
`ifdef DATAPATH_DIV_EN
         ALU_DIV:  z_d = {div_rem, div_quo};
`endif
         ALU_SHR:  z_d = {32'h0, alu_a >> sh};
         ALU_SHRA: z_d = {32'h0, $signed(alu_a) >>> sh};
         ALU_SHL:  z_d = {32'h0, alu_a << sh};
         ALU_ROR:  z_d = {32'h0, 32'({alu_a, alu_a} >> sh)};
         ALU_ROL:  z_d = {32'h0, 32'({alu_a, alu_a} >> (6'd32 - {1'b0, sh}))};
         ALU_NEG:  z_d = {32'h0, 32'h0 - alu_b};
         default:  z_d = '0;
      endcase
   end

   // NOTE: the register file is an array but still gets the asynchronous clear,
   // since every register must read 0 immediately after clear; sequential state
   // is written only with non-blocking '<='.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < 16; i++) r_q[i] <= '0;
         ra_q   <= '0;
         pc_q   <= '0;
         ir_q   <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         mdr_q  <= '0;
         y_q    <= '0;
         port_q <= '0;
         z_q    <= '0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (r_in[i]) r_q[i] <= bus;
         end
         if (RAin)   ra_q   <= bus;
         if (PCin)   pc_q   <= bus;
         if (IRin)   ir_q   <= bus;
         if (HIin)   hi_q   <= bus;
         if (LOin)   lo_q   <= bus;
         if (RYin)   y_q    <= bus;
         if (PORTin) port_q <= bus;
         if (MDRin)  mdr_q  <= mdr_d;
         if (RZin)   z_q    <= z_d;
      end
   end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed test-plan cases plus random strobe traffic
// against a register-array reference model. Honours DATAPATH_DIV_EN for DIV expectations.
module tb_data_path;

   localparam int S_RA = 16, S_PC = 17, S_IR = 18, S_HI = 19, S_LO = 20;
   localparam int S_ZHI = 21, S_ZLO = 22, S_MDR = 23, S_PORT = 24, S_Y = 25;
   localparam int D_RA = 16, D_PC = 17, D_IR = 18, D_HI = 19, D_LO = 20;
   localparam int D_MDR = 21, D_PORT = 22, D_Y = 23, D_Z = 24;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] mdatain;
   logic [4:0]  ops;
   logic [25:0] out_v;
   logic [24:0] in_v;
   logic        read;
   logic [31:0] bus;

   int n_checks = 0;
   int n_bad    = 0;

   // Model state indexed by bus-source id; Z is held as its two halves.
   logic [31:0] m_reg [26];

   always #5 clock = ~clock;

   data_path dut (
      .clock(clock), .clear(clear), .Mdatain(mdatain), .ops(ops),
      .RAout(out_v[S_RA]),
      .R0out(out_v[0]),   .R1out(out_v[1]),   .R2out(out_v[2]),   .R3out(out_v[3]),
      .R4out(out_v[4]),   .R5out(out_v[5]),   .R6out(out_v[6]),   .R7out(out_v[7]),
      .R8out(out_v[8]),   .R9out(out_v[9]),   .R10out(out_v[10]), .R11out(out_v[11]),
      .R12out(out_v[12]), .R13out(out_v[13]), .R14out(out_v[14]), .R15out(out_v[15]),
      .RYout(out_v[S_Y]), .RZHIout(out_v[S_ZHI]), .RZLOout(out_v[S_ZLO]),
      .PCout(out_v[S_PC]), .IRout(out_v[S_IR]), .HIout(out_v[S_HI]), .LOout(out_v[S_LO]),
      .MDRout(out_v[S_MDR]), .PORTout(out_v[S_PORT]),
      .RAin(in_v[D_RA]),
      .R0in(in_v[0]),   .R1in(in_v[1]),   .R2in(in_v[2]),   .R3in(in_v[3]),
      .R4in(in_v[4]),   .R5in(in_v[5]),   .R6in(in_v[6]),   .R7in(in_v[7]),
      .R8in(in_v[8]),   .R9in(in_v[9]),   .R10in(in_v[10]), .R11in(in_v[11]),
      .R12in(in_v[12]), .R13in(in_v[13]), .R14in(in_v[14]), .R15in(in_v[15]),
      .RYin(in_v[D_Y]), .RZin(in_v[D_Z]), .PCin(in_v[D_PC]), .IRin(in_v[D_IR]),
      .HIin(in_v[D_HI]), .LOin(in_v[D_LO]), .MDRin(in_v[D_MDR]), .PORTin(in_v[D_PORT]),
      .Read(read),
      .BusMuxOut(bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint      sa, sb, q, r;
      int          s;
      logic [31:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s  = int'(b % 32);
      t  = a;
      case (op)
         5'd0:  return {32'h0, a + b};
         5'd1:  return {32'h0, a - b};
         5'd2:  return {32'h0, a & b};
         5'd3:  return {32'h0, a | b};
         5'd4:  return {32'h0, ~b};
         5'd5:  return 64'(sa * sb);
         5'd6: begin
`ifdef DATAPATH_DIV_EN
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
`else
            return 64'h0;
`endif
         end
         5'd7:  return {32'h0, a >> s};
         5'd8: begin
            r = sa >>> s;
            return {32'h0, r[31:0]};
         end
         5'd9:  return {32'h0, a << s};
         5'd10: begin
            repeat (s) t = {t[0], t[31:1]};
            return {32'h0, t};
         end
         5'd11: begin
            repeat (s) t = {t[30:0], t[31]};
            return {32'h0, t};
         end
         5'd12: return {32'h0, 32'h0 - b};
         default: return 64'h0;
      endcase
   endfunction

   function automatic logic [31:0] model_bus();
      for (int i = 0; i < 26; i++) begin
         if (out_v[i]) return m_reg[i];
      end
      return 32'h0;
   endfunction

   // Strobes are already set; check the bus, take one rising edge, update the model.
   task automatic cycle(input string tag);
      logic [31:0] b;
      logic [63:0] z;
      #1;
      b = model_bus();
      check({tag, "/bus"}, bus, b);
      z = ref_alu(ops, m_reg[S_Y], b);
      @(posedge clock);
      #1;
      for (int d = 0; d <= D_LO; d++) begin
         if (in_v[d]) m_reg[d] = b;
      end
      if (in_v[D_MDR])  m_reg[S_MDR]  = read ? mdatain : b;
      if (in_v[D_PORT]) m_reg[S_PORT] = b;
      if (in_v[D_Y])    m_reg[S_Y]    = b;
      if (in_v[D_Z]) begin
         m_reg[S_ZHI] = z[63:32];
         m_reg[S_ZLO] = z[31:0];
      end
      out_v = '0;
      in_v  = '0;
   endtask

   task automatic peek(input int src, input logic [31:0] exp, input string tag);
      @(negedge clock);
      out_v      = '0;
      out_v[src] = 1'b1;
      #1;
      check(tag, bus, exp);
      out_v = '0;
   endtask

   task automatic load(input int dst, input logic [31:0] val);
      read           = 1'b1;
      mdatain        = val;
      in_v[D_MDR]    = 1'b1;
      cycle("ld_mdr");
      read           = 1'b0;
      out_v[S_MDR]   = 1'b1;
      in_v[dst]      = 1'b1;
      cycle("ld_dst");
   endtask

   task automatic alu_to_z(input logic [4:0] op, input int bsrc);
      ops         = op;
      out_v[bsrc] = 1'b1;
      in_v[D_Z]   = 1'b1;
      cycle($sformatf("op%0d", op));
   endtask

   task automatic sweep();
      for (int i = 0; i < 26; i++) peek(i, m_reg[i], $sformatf("sweep_src%0d", i));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      logic [31:0] md;
      clear   = 1'b0;
      mdatain = '0;
      ops     = '0;
      out_v   = '0;
      in_v    = '0;
      read    = 1'b0;
      for (int i = 0; i < 26; i++) m_reg[i] = 32'h0;
      repeat (2) @(posedge clock);
      #2;
      clear = 1'b1;

      // Reset state: every source reads zero, idle bus is zero.
      for (int i = 0; i < 26; i++) peek(i, 32'h0, $sformatf("reset_src%0d", i));
      #1;
      check("idle_bus", bus, 32'h0);

      // MUL sequence from the test plan, driven strobe by strobe.
      @(negedge clock);
      read = 1'b1; mdatain = 32'hFFFF_FFFD; in_v[D_MDR] = 1'b1;
      cycle("mul_s1");
      out_v[S_MDR] = 1'b1; in_v[D_Y] = 1'b1;
      cycle("mul_s2");
      mdatain = 32'd4; in_v[D_MDR] = 1'b1;
      cycle("mul_s3");
      read = 1'b0; out_v[S_MDR] = 1'b1; in_v[2] = 1'b1;
      cycle("mul_s4");
      ops = 5'b00101; out_v[2] = 1'b1; out_v[S_Y] = 1'b1; in_v[D_Z] = 1'b1;
      #1;
      check("mul_r2_wins_bus", bus, 32'd4);
      cycle("mul_s5");
      out_v[S_ZLO] = 1'b1; in_v[1] = 1'b1;
      cycle("mul_s6");
      out_v[S_ZHI] = 1'b1; in_v[D_HI] = 1'b1;
      cycle("mul_s7");
      peek(1, 32'hFFFF_FFF4, "mul_r1");
      peek(S_HI, 32'hFFFF_FFFF, "mul_hi");

      // ADD / SUB.
      load(D_Y, 32'd7);
      load(3, 32'd5);
      alu_to_z(5'b00000, 3);
      peek(S_ZLO, 32'd12, "add_zlo");
      peek(S_ZHI, 32'd0, "add_zhi");
      alu_to_z(5'b00001, 3);
      peek(S_ZLO, 32'd2, "sub_zlo");
      load(D_Y, 32'd0);
      load(4, 32'd1);
      alu_to_z(5'b00001, 4);
      peek(S_ZLO, 32'hFFFF_FFFF, "sub_wrap");

      // Shifts and rotates, including a shift count of 33.
      load(D_Y, 32'h8000_0001);
      alu_to_z(5'b00111, 4); peek(S_ZLO, 32'h4000_0000, "shr");
      alu_to_z(5'b01000, 4); peek(S_ZLO, 32'hC000_0000, "shra");
      alu_to_z(5'b01011, 4); peek(S_ZLO, 32'h0000_0003, "rol");
      alu_to_z(5'b01010, 4); peek(S_ZLO, 32'hC000_0000, "ror");
      load(4, 32'd33);
      alu_to_z(5'b00111, 4); peek(S_ZLO, 32'h4000_0000, "shr_33");
      alu_to_z(5'b01011, 4); peek(S_ZLO, 32'h0000_0003, "rol_33");

      // DIV, including divide by zero.
      load(D_Y, 32'hFFFF_FFF9);
      load(4, 32'd2);
      alu_to_z(5'b00110, 4);
`ifdef DATAPATH_DIV_EN
      peek(S_ZLO, 32'hFFFF_FFFD, "div_quo");
      peek(S_ZHI, 32'hFFFF_FFFF, "div_rem");
`else
      peek(S_ZLO, 32'h0, "div_off_lo");
      peek(S_ZHI, 32'h0, "div_off_hi");
`endif
      load(4, 32'd0);
      alu_to_z(5'b00110, 4);
`ifdef DATAPATH_DIV_EN
      peek(S_ZLO, 32'hFFFF_FFFF, "div0_quo");
      peek(S_ZHI, 32'hFFFF_FFF9, "div0_rem");
`else
      peek(S_ZLO, 32'h0, "div0_off_lo");
      peek(S_ZHI, 32'h0, "div0_off_hi");
`endif

      // MDR input select.
      load(5, 32'h1234);
      read = 1'b0; out_v[5] = 1'b1; in_v[D_MDR] = 1'b1;
      cycle("mdr_bus");
      peek(S_MDR, 32'h1234, "mdr_from_bus");
      md = $urandom;
      read = 1'b1; mdatain = md; in_v[D_MDR] = 1'b1;
      #1;
      check("mdr_idle_bus", bus, 32'h0);
      cycle("mdr_mem");
      read = 1'b0;
      peek(S_MDR, md, "mdr_from_mem");

      // Clear pulsed between edges in the middle of a sequence.
      load(1, 32'hAA);
      load(D_Y, 32'd1);
      load(4, 32'd2);
      alu_to_z(5'b00000, 4);
      load(D_HI, 32'h77);
      @(posedge clock);
      #3;
      clear = 1'b0;
      for (int i = 0; i < 26; i++) m_reg[i] = 32'h0;
      out_v[1] = 1'b1;     #1; check("clr_r1", bus, 32'h0);
      out_v = '0; out_v[S_ZLO] = 1'b1; #1; check("clr_zlo", bus, 32'h0);
      out_v = '0; out_v[S_ZHI] = 1'b1; #1; check("clr_zhi", bus, 32'h0);
      out_v = '0; out_v[S_HI] = 1'b1;  #1; check("clr_hi", bus, 32'h0);
      out_v = '0;
      #1;
      check("clr_idle_bus", bus, 32'h0);
      clear = 1'b1;
      load(1, 32'h55);
      peek(1, 32'h55, "post_clr_load");

      // Random strobe traffic against the model.
      for (int it = 0; it < 400; it++) begin
         @(negedge clock);
         ops     = 5'($urandom_range(0, 15));
         read    = 1'($urandom);
         mdatain = $urandom;
         repeat ($urandom_range(0, 3)) out_v[$urandom_range(0, 25)] = 1'b1;
         repeat ($urandom_range(1, 2)) in_v[$urandom_range(0, 24)] = 1'b1;
         cycle($sformatf("rnd%0d", it));
         if (it % 100 == 99) sweep();
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
